// File: rtl/lm75_monitor_pkg.sv
// Shared types and constants for the LM75 temperature monitor.
package lm75_monitor_pkg;

    // Sweep controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CONV  = 3'd3,
        ST_STORE = 3'd4
    } state_t;

    // One decoded reading per sensor, ready for the display mux.
    typedef struct packed {
        logic       sign;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
        logic       half;
        logic       valid;
    } chan_rec_t;

    // Alarm set / clear thresholds in 0.5 degC units (80.0 / 75.0 degC).
    localparam logic signed [8:0] T_OS_DEFAULT   = 9'sd160;
    localparam logic signed [8:0] T_HYST_DEFAULT = 9'sd150;

    // Magnitude of a signed 9-bit reading; 10 bits so that -256 maps to 256.
    function automatic logic [9:0] abs9(input logic signed [8:0] raw);
        logic [9:0] ext;
        ext = {raw[8], raw};
        return raw[8] ? (10'd0 - ext) : ext;
    endfunction

endpackage

// File: rtl/lm75_monitor_bcd_seq8.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3),
// one shift per cycle, exactly 8 cycles from start to result.
module bcd_seq8
    import lm75_monitor_pkg::*;
(
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic        o_done,
    output logic [11:0] o_bcd
);

    // [19:8] BCD accumulator, [7:0] binary bits still to be shifted in.
    logic [19:0] r_sh;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic [19:0] w_adj;

    genvar gi;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    assign w_adj[7:0] = r_sh[7:0];
    for (gi = 0; gi < 3; gi++) begin : g_digit
        assign w_adj[8 + 4*gi +: 4] = (r_sh[8 + 4*gi +: 4] >= 4'd5) ?
                                      (r_sh[8 + 4*gi +: 4] + 4'd3) :
                                      r_sh[8 + 4*gi +: 4];
    end

    // Load on start, then shift once per cycle for 8 cycles.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_sh   <= {12'd0, i_bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sh  <= w_adj << 1;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Done is high during the cycle whose closing edge performs the last shift.
    assign o_done = r_busy && (r_cnt == 3'd7);
    assign o_bcd  = r_sh[19:8];

endmodule

// File: rtl/lm75_monitor.sv
// Polls up to eight LM75 sensors over a simple I2C read port, decodes the
// temperature to sign/BCD/half-degree, keeps alarm and fault flags per
// channel, and shows one selected channel on registered display outputs.
module lm75_monitor
    import lm75_monitor_pkg::*;
#(
    parameter int                N_CH           = 4,
    parameter logic [6:0]        BASE_ADDR      = 7'h48,
    parameter int                POLL_CYCLES    = 50_000_000,
    parameter int                TIMEOUT_CYCLES = 1_000_000,
    parameter logic signed [8:0] T_OS           = T_OS_DEFAULT,
    parameter logic signed [8:0] T_HYST         = T_HYST_DEFAULT
) (
    input  logic            CLK,
    input  logic            rst_n,
    output logic            i2c_req,
    output logic [6:0]      i2c_addr,
    input  logic            i2c_ack,
    input  logic            i2c_err,
    input  logic [15:0]     i2c_data,
    input  logic [2:0]      disp_sel,
    output logic            sign,
    output logic [3:0]      hundreds,
    output logic [3:0]      tens,
    output logic [3:0]      units,
    output logic            half,
    output logic            disp_valid,
    output logic [N_CH-1:0] alarm,
    output logic [N_CH-1:0] fault,
    output logic            busy
);

    state_t              r_state;
    logic [2:0]          r_ch;
    logic [31:0]         r_poll_cnt;
    logic [31:0]         r_wait_cnt;
    logic signed [8:0]   r_raw;
    logic                r_half;

    logic                w_tick;
    logic                w_timeout;
    logic                w_fault_set;
    logic                w_store;
    logic                w_conv_start;
    logic                w_last;
    logic signed [8:0]   w_raw_in;
    logic [9:0]          w_mag_in;
    logic                w_bcd_done;
    logic [11:0]         w_bcd;
    logic                w_unused;
    chan_rec_t           w_rec_all [8];

    genvar gi;

    // Decode the incoming register straight off the bus so the converter
    // can start on the same edge that samples the ack.
    assign w_raw_in = i2c_data[15:7];
    assign w_mag_in = abs9(w_raw_in);
    assign w_unused = ^{w_mag_in[9], i2c_data[6:0]};

    assign w_tick       = (r_poll_cnt == 32'(POLL_CYCLES - 1));
    assign w_timeout    = (r_state == ST_WAIT) && !i2c_ack &&
                          (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_fault_set  = (r_state == ST_WAIT) && ((i2c_ack && i2c_err) || w_timeout);
    assign w_conv_start = (r_state == ST_WAIT) && i2c_ack && !i2c_err;
    assign w_store      = (r_state == ST_STORE);
    assign w_last       = (r_ch == 3'(N_CH - 1));
    assign busy         = (r_state != ST_IDLE);

    // Free-running sweep period counter; wraps whether or not a sweep starts.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_poll_cnt <= '0;
        end else if (w_tick) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
        end
    end

    // Sweep controller: request, wait for ack or timeout, convert, store.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ch       <= '0;
            r_wait_cnt <= '0;
            r_raw      <= '0;
            r_half     <= 1'b0;
            i2c_req    <= 1'b0;
            i2c_addr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_ch    <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    i2c_req    <= 1'b1;
                    i2c_addr   <= BASE_ADDR + {4'd0, r_ch};
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c_ack) begin
                        i2c_req <= 1'b0;
                        if (i2c_err) begin
                            r_state <= w_last ? ST_IDLE : ST_REQ;
                            r_ch    <= w_last ? r_ch : r_ch + 3'd1;
                        end else begin
                            r_raw   <= w_raw_in;
                            r_half  <= w_mag_in[0];
                            r_state <= ST_CONV;
                        end
                    end else if (w_timeout) begin
                        i2c_req <= 1'b0;
                        r_state <= w_last ? ST_IDLE : ST_REQ;
                        r_ch    <= w_last ? r_ch : r_ch + 3'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                ST_CONV: begin
                    if (w_bcd_done) begin
                        r_state <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    r_state <= w_last ? ST_IDLE : ST_REQ;
                    r_ch    <= w_last ? r_ch : r_ch + 3'd1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bcd_seq8 u_bcd (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .i_start (w_conv_start),
        .i_bin   (w_mag_in[8:1]),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    // Per-channel record and flags; unused slots of the 8-way mux read as zero.
    for (gi = 0; gi < 8; gi++) begin : g_ch
        if (gi < N_CH) begin : g_live
            chan_rec_t r_rec;
            logic      r_alarm;
            logic      r_fault;
            logic      w_sel;

            assign w_sel = (r_ch == 3'(gi));

            // Latch fault on a failed read; store the decoded reading and
            // update the hysteretic alarm on a good one.
            always_ff @(posedge CLK) begin
                if (!rst_n) begin
                    r_rec   <= '0;
                    r_alarm <= 1'b0;
                    r_fault <= 1'b0;
                end else if (w_sel && w_fault_set) begin
                    r_fault <= 1'b1;
                end else if (w_sel && w_store) begin
                    r_fault        <= 1'b0;
                    r_rec.sign     <= r_raw[8] && (r_raw != 9'sd0);
                    r_rec.hundreds <= w_bcd[11:8];
                    r_rec.tens     <= w_bcd[7:4];
                    r_rec.units    <= w_bcd[3:0];
                    r_rec.half     <= r_half;
                    r_rec.valid    <= 1'b1;
                    if (r_raw >= T_OS) begin
                        r_alarm <= 1'b1;
                    end else if (r_raw < T_HYST) begin
                        r_alarm <= 1'b0;
                    end
                end
            end

            assign w_rec_all[gi] = r_rec;
            assign alarm[gi]     = r_alarm;
            assign fault[gi]     = r_fault;
        end else begin : g_pad
            assign w_rec_all[gi] = '0;
        end
    end

    // Display register follows disp_sel every cycle, including mid-sweep.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sign       <= 1'b0;
            hundreds   <= '0;
            tens       <= '0;
            units      <= '0;
            half       <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            sign       <= w_rec_all[disp_sel].sign;
            hundreds   <= w_rec_all[disp_sel].hundreds;
            tens       <= w_rec_all[disp_sel].tens;
            units      <= w_rec_all[disp_sel].units;
            half       <= w_rec_all[disp_sel].half;
            disp_valid <= w_rec_all[disp_sel].valid;
        end
    end

endmodule

// File: tb/tb_lm75_monitor.sv
// Directed/randomised bench for lm75_monitor with a behavioural model of
// the decoded temperature, alarm hysteresis and fault flags.
module tb_lm75_monitor;

    localparam int N_CH = 4;
    localparam int POLL = 300;
    localparam int TMO  = 40;

    logic            CLK = 1'b0;
    logic            rst_n = 1'b0;
    logic            i2c_ack = 1'b0;
    logic            i2c_err = 1'b0;
    logic [15:0]     i2c_data = '0;
    logic [2:0]      disp_sel = '0;
    logic            i2c_req;
    logic [6:0]      i2c_addr;
    logic            sign;
    logic [3:0]      hundreds;
    logic [3:0]      tens;
    logic [3:0]      units;
    logic            half;
    logic            disp_valid;
    logic [N_CH-1:0] alarm;
    logic [N_CH-1:0] fault;
    logic            busy;

    int checks = 0;
    int errors = 0;

    int m_raw   [N_CH];
    bit m_valid [N_CH];
    bit m_alarm [N_CH];
    bit m_fault [N_CH];

    lm75_monitor #(
        .N_CH           (N_CH),
        .BASE_ADDR      (7'h48),
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO),
        .T_OS           (9'sd160),
        .T_HYST         (9'sd150)
    ) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .i2c_req    (i2c_req),
        .i2c_addr   (i2c_addr),
        .i2c_ack    (i2c_ack),
        .i2c_err    (i2c_err),
        .i2c_data   (i2c_data),
        .disp_sel   (disp_sel),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .units      (units),
        .half       (half),
        .disp_valid (disp_valid),
        .alarm      (alarm),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_CH; i++) begin
            m_raw[i] = 0; m_valid[i] = 0; m_alarm[i] = 0; m_fault[i] = 0;
        end
    endtask

    // Expected display for a channel, derived from the temperature in 0.5 degC.
    task automatic check_disp(input int sel, input string tag);
        int s, h, t, u, hf, v, a, n;
        s = 0; h = 0; t = 0; u = 0; hf = 0; v = 0;
        if (sel < N_CH) begin
            if (m_valid[sel]) begin
                a  = (m_raw[sel] < 0) ? -m_raw[sel] : m_raw[sel];
                n  = a / 2;
                hf = a % 2;
                s  = (m_raw[sel] < 0) ? 1 : 0;
                h  = n / 100;
                t  = (n / 10) % 10;
                u  = n % 10;
                v  = 1;
            end
        end
        check({tag, "_sign"},  sign,       s);
        check({tag, "_hund"},  hundreds,   h);
        check({tag, "_tens"},  tens,       t);
        check({tag, "_units"}, units,      u);
        check({tag, "_half"},  half,       hf);
        check({tag, "_valid"}, disp_valid, v);
    endtask

    task automatic check_flags(input string tag);
        logic [N_CH-1:0] ea, ef;
        for (int i = 0; i < N_CH; i++) begin
            ea[i] = m_alarm[i];
            ef[i] = m_fault[i];
        end
        check({tag, "_alarm"}, alarm, ea);
        check({tag, "_fault"}, fault, ef);
    endtask

    // Act as the I2C master port for one channel of a sweep.
    task automatic serve(input int ch, input logic [15:0] d, input bit err, input bit noack);
        int n, sel, dl;
        logic signed [8:0] rr;
        disp_sel = 3'(ch);
        n = 0;
        while (!i2c_req && n < 1000) begin
            tick();
            n++;
        end
        check("req_seen", i2c_req, 1);
        if (!i2c_req) return;
        check("addr", i2c_addr, 32'h48 + ch);
        check("busy", busy, 1);
        if (noack) begin
            n = 0;
            while (i2c_req && n < 1000) begin
                tick();
                n++;
            end
            check("timeout_len", n, TMO);
            m_fault[ch] = 1;
            check_flags("timeout");
            return;
        end
        sel = $urandom_range(0, 7);
        disp_sel = 3'(sel);
        tick();
        check_disp(sel, "sel_change");
        disp_sel = 3'(ch);
        dl = $urandom_range(0, 2);
        repeat (dl) tick();
        check("req_hold", i2c_req, 1);
        check("addr_hold", i2c_addr, 32'h48 + ch);
        i2c_ack  = 1'b1;
        i2c_err  = err;
        i2c_data = d;
        tick();
        i2c_ack  = 1'b0;
        i2c_err  = 1'b0;
        i2c_data = 16'($urandom);
        check("req_drop", i2c_req, 0);
        if (err) begin
            m_fault[ch] = 1;
            check_flags("err");
            check_disp(ch, "err_keep");
            return;
        end
        repeat (9) tick();
        check_disp(ch, "pre");
        rr = d[15:7];
        m_raw[ch]   = int'(rr);
        m_valid[ch] = 1;
        m_fault[ch] = 0;
        if (m_raw[ch] >= 160) m_alarm[ch] = 1;
        else if (m_raw[ch] < 150) m_alarm[ch] = 0;
        tick();
        check_disp(ch, "disp");
        check_flags("read");
        $display("ch%0d data=%h err=%0d raw=%0d disp=%0d%0d%0d.%0d sign=%0d", ch, d, err,
                 m_raw[ch], hundreds, tens, units, half, sign);
    endtask

    task automatic sweep(input logic [63:0] ds, input logic [3:0] errs, input logic [3:0] noacks);
        for (int c = 0; c < N_CH; c++) begin
            serve(c, ds[16*c +: 16], errs[c], noacks[c]);
        end
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    initial begin
        int n;
        model_clear();
        // Reset state
        repeat (3) tick();
        check("rst_req", i2c_req, 0);
        check("rst_busy", busy, 0);
        check_disp(0, "rst");
        check_flags("rst");
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_early_sweep", busy, 0);
        check("no_early_req", i2c_req, 0);

        sweep({16'h7D00, 16'hC900, 16'hFF80, 16'h1900}, 4'b0000, 4'b0000);
        sweep({rnd16(), 16'h1900, 16'h5000, 16'h0000}, 4'b0000, 4'b0000);
        sweep({rnd16(), rnd16(), 16'h4C00, rnd16()}, 4'b0100, 4'b0000);
        sweep({rnd16(), rnd16(), 16'h4A80, rnd16()}, 4'b0000, 4'b0000);
        sweep({rnd16(), rnd16(), 16'h4B00, 16'h8000}, 4'b0000, 4'b0000);
        sweep({rnd16(), rnd16(), 16'h5000, rnd16()}, 4'b1000, 4'b0000);
        sweep({rnd16(), rnd16(), 16'h4B00, rnd16()}, 4'b0000, 4'b0000);
        sweep({rnd16(), rnd16(), rnd16(), rnd16()}, 4'b0000, 4'b0010);

        // Reset in the middle of a transaction
        disp_sel = 3'd0;
        n = 0;
        while (!i2c_req && n < 1000) begin
            tick();
            n++;
        end
        check("mid_req_seen", i2c_req, 1);
        rst_n = 1'b0;
        tick();
        model_clear();
        check("mid_rst_req", i2c_req, 0);
        check("mid_rst_addr", i2c_addr, 0);
        check("mid_rst_busy", busy, 0);
        check_disp(0, "mid_rst");
        check_flags("mid_rst");
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm75_monitor.md
LM75_MONITOR -- requirements
Module: lm75_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of LM75 sensors polled (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 7'h48, meaning I2C address of channel 0; channel k uses BASE_ADDR+k.
REQ-003 SHALL have parameter POLL_CYCLES, default 50_000_000, meaning CLK cycles between sweep starts.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning maximum cycles waiting for i2c_ack.
REQ-005 SHALL have parameters T_OS, default 160, and T_HYST, default 150, meaning signed 9-bit alarm set/clear thresholds in 0.5 °C units.
REQ-006 SHALL have ports, clock and reset first: CLK in 1 system clock; rst_n in 1 reset; i2c_req out 1 read request; i2c_addr out 7 target address; i2c_ack in 1 transaction done; i2c_err in 1 NACK flag, valid with ack; i2c_data in 16 temperature register; disp_sel in 3 channel to display; sign out 1 negative; hundreds, tens, units out 4 each, BCD integer degrees; half out 1 .5 °C; disp_valid out 1; alarm out N_CH; fault out N_CH; busy out 1 sweep active.
REQ-007 SHALL use one clock, CLK; reset rst_n SHALL be synchronous and active-low.

Function
REQ-008 SHALL run a free-running poll counter 0..POLL_CYCLES-1; at wrap it SHALL start a sweep if IDLE, else the tick is dropped and the counter still wraps.
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT, CONV, STORE; a sweep visits channels 0..N_CH-1 in order, then returns to IDLE.
REQ-010 REQ SHALL assert i2c_req with i2c_addr=BASE_ADDR+ch and move to WAIT; i2c_req and i2c_addr SHALL hold until the cycle i2c_ack is sampled high.
REQ-011 In WAIT, ack with err=0 SHALL capture raw=i2c_data[15:7] as a signed 9-bit value and go to CONV.
REQ-012 In WAIT, ack with err=1, or TIMEOUT_CYCLES elapsed without ack, SHALL set fault[ch], keep the stored value, and advance to the next channel. i2c_req SHALL drop on timeout.
REQ-013 A successful read SHALL clear fault[ch].
REQ-014 CONV SHALL compute mag=|raw| (10-bit), integer=mag>>1 (0..128), half=mag[0], and sign=raw[8]; sign SHALL be forced to 0 when mag=0.
REQ-015 CONV SHALL convert the integer to 3 BCD digits by sequential shift-add-3 in exactly 8 cycles; STORE SHALL take 1 cycle.
REQ-016 Latency from the ack cycle to updated display outputs for a selected channel SHALL be 11 cycles: CONV 8, STORE 1, output register 1, plus the ack cycle.
REQ-017 Alarm: in STORE, alarm[ch] SHALL set when raw>=T_OS and clear when raw<T_HYST, using a signed compare; otherwise it holds.
REQ-018 Display outputs SHALL be registered from the stored record of channel disp_sel; disp_valid=1 only if that channel has had at least one successful read.
REQ-019 disp_sel>=N_CH SHALL give disp_valid=0 and zero digits.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 A disp_sel change SHALL be reflected one cycle later, even mid-sweep.

Reset
REQ-022 With rst_n low at a CLK edge, all outputs, stored records, the poll counter and the FSM (IDLE) SHALL clear to 0, including mid-transaction; i2c_req SHALL be 0 after that edge.
REQ-023 After reset, the first sweep SHALL start at the first poll counter wrap, not immediately.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the per-channel record type (sign, 3 BCD digits, half, valid), and the default threshold constants.
REQ-025 The binary-to-BCD converter SHALL be one sub-module, bcd_seq8: start/done handshake, 8-bit in, 12-bit out.

Verification
REQ-026 16'h1900 on ch0 -> sign 0, digits 0/2/5, half 0, disp_valid 1, 11 cycles after ack.
REQ-027 16'hFF80 -> sign 1, digits 0/0/0, half 1; 16'h0000 -> sign 0; 16'hC900 -> sign 1, digits 0/5/5, half 0; 16'h7D00 -> 1/2/5.
REQ-028 Successive reads 16'h5000, 16'h4C00, 16'h4A80 -> alarm set, stays set, clears; 16'h4B00 (75.0) holds.
REQ-029 i2c_err=1 on ch2 after a prior 16'h1900 -> fault[2]=1, display still 25.0; next good read clears fault[2].
REQ-030 No ack for TIMEOUT_CYCLES on ch1 -> fault[1]=1, i2c_req drops, sweep continues on ch2; rst_n low mid-WAIT -> i2c_req=0 and all outputs 0 next cycle.
